// File: rtl/fpu_addsub_pkg.sv
// Shared types and defaults for the FPU add/subtract datapath.
// FSM state encoding, rounding-mode codes, default field widths.
package fpu_addsub_pkg;

  localparam int W_DEF   = 32;
  localparam int EW_DEF  = 8;
  localparam int SW_DEF  = 23;
  localparam int SWR_DEF = 26;
  localparam int EWR_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [1:0] RM_ZERO = 2'b00;
  localparam logic [1:0] RM_PINF = 2'b01;
  localparam logic [1:0] RM_NINF = 2'b10;
  localparam logic [1:0] RM_NEAR = 2'b11;

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter for the normalisation step.
// All-zero input reports WIDTH.
module fpu_lzc
  import fpu_addsub_pkg::*;
#(
  parameter int WIDTH = SWR_DEF,
  parameter int CW    = EWR_DEF
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  // highest set bit wins, since later iterations overwrite earlier ones
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_add_subtract_function.sv
// Multi-cycle IEEE-754 adder/subtractor with start/ready FSM.
// Define FPU_ADDSUB_SPECIAL_EN to decode inf/NaN operands.
module fpu_add_subtract_function
  import fpu_addsub_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int EW  = EW_DEF,
  parameter int SW  = SW_DEF,
  parameter int SWR = SWR_DEF,
  parameter int EWR = EWR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rst_FSM,
  input  logic         beg_FSM,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  input  logic         add_subt,
  input  logic [1:0]   r_mode,
  output logic         overflow_flag,
  output logic         underflow_flag,
  output logic         ready,
  output logic [W-1:0] final_result_ieee
);

  // carry, hidden, fraction, guard, round
  localparam int N    = SWR + 1;
  localparam int XW   = EW + 2;
  localparam int EMAX = (1 << EW) - 1;

  state_t r_state, w_next;
  logic   r_ready;

  logic [W-1:0] r_x, r_y;
  logic         r_op;
  logic [1:0]   r_rm;

  logic          r_sx, r_sy;
  logic [EW-1:0] r_ex, r_ey;
  logic [N-1:0]  r_mx, r_my;
  logic          r_st;
  logic [N-1:0]  r_sum;
  logic signed [XW-1:0] r_exp;
  logic          r_zero;
  logic          r_spec;
  logic [W-1:0]  r_spec_val;

  logic [W-1:0] r_res;
  logic         r_ovf, r_unf;

  logic w_start, w_fin;

  // start and completion strobes; rst_FSM outranks both
  always_comb begin
    w_start = beg_FSM && !rst_FSM &&
              (r_state == S_IDLE || r_state == S_DONE);
    w_fin   = (r_state == S_ROUND) && !rst_FSM;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (beg_FSM) w_next = S_LOAD;
      S_LOAD:  w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // state register; ready rises once DONE is held a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else if (rst_FSM) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (r_state == S_DONE) && !beg_FSM;
    end
  end

  logic          w_xs, w_ys, w_swap;
  logic [EW-1:0] w_xe, w_ye;
  logic [N-1:0]  w_xm, w_ym;

  // unpack captured operands, flush zero exponents, order by magnitude
  always_comb begin
    w_xs = r_x[W-1];
    w_ys = r_y[W-1] ^ r_op;
    w_xe = r_x[W-2:SW];
    w_ye = r_y[W-2:SW];
    w_xm = '0;
    w_ym = '0;
    if (w_xe != '0) w_xm = {2'b01, r_x[SW-1:0], 2'b00};
    if (w_ye != '0) w_ym = {2'b01, r_y[SW-1:0], 2'b00};
    w_swap = {w_ye, w_ym} > {w_xe, w_xm};
  end

  logic         w_spec;
  logic [W-1:0] w_spec_val;

`ifdef FPU_ADDSUB_SPECIAL_EN
  logic w_xinf, w_yinf, w_xnan, w_ynan;

  // inf/NaN decode; these bypass the arithmetic result
  always_comb begin
    w_xinf = (&w_xe) && (r_x[SW-1:0] == '0);
    w_yinf = (&w_ye) && (r_y[SW-1:0] == '0);
    w_xnan = (&w_xe) && (r_x[SW-1:0] != '0);
    w_ynan = (&w_ye) && (r_y[SW-1:0] != '0);
    w_spec = w_xinf || w_yinf || w_xnan || w_ynan;
    if (w_xnan || w_ynan || (w_xinf && w_yinf && (w_xs != w_ys)))
      w_spec_val = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
    else if (w_xinf)
      w_spec_val = {w_xs, {EW{1'b1}}, {SW{1'b0}}};
    else
      w_spec_val = {w_ys, {EW{1'b1}}, {SW{1'b0}}};
  end
`else
  // all-ones exponents are ordinary finite values here
  always_comb begin
    w_spec     = 1'b0;
    w_spec_val = '0;
  end
`endif

  logic [EW-1:0]  w_diff;
  logic [EWR-1:0] w_sh;
  logic [N-1:0]   w_mys;
  logic           w_lost;

  // alignment shift with sticky collection
  always_comb begin
    w_diff = r_ex - r_ey;
    if (int'(w_diff) >= SWR) w_sh = EWR'(SWR);
    else                     w_sh = w_diff[EWR-1:0];
    w_mys  = r_my >> w_sh;
    w_lost = |(r_my & ~({N{1'b1}} << w_sh));
  end

  logic [EWR-1:0] w_lz;

  fpu_lzc #(
    .WIDTH(SWR),
    .CW   (EWR)
  ) u_lzc (
    .i_data (r_sum[N-2:0]),
    .o_count(w_lz)
  );

  logic [SW:0]   w_m;
  logic          w_g, w_rest, w_inc;
  logic [SW+1:0] w_mr;
  logic signed [XW-1:0] w_ef;
  logic [SW-1:0] w_fr;
  logic [W-1:0]  w_res;
  logic          w_ovf, w_unf;

  // rounding, renormalisation on carry, and range checks
  always_comb begin
    w_m    = r_sum[N-2:2];
    w_g    = r_sum[1];
    w_rest = r_sum[0] | r_st;
    w_inc  = 1'b0;
    unique case (r_rm)
      RM_ZERO: w_inc = 1'b0;
      RM_PINF: w_inc = !r_sx && (w_g || w_rest);
      RM_NINF: w_inc = r_sx && (w_g || w_rest);
      RM_NEAR: w_inc = w_g && (w_rest || w_m[0]);
      default: w_inc = 1'b0;
    endcase
    w_mr = {1'b0, w_m} + {{(SW+1){1'b0}}, w_inc};
    w_ef = r_exp;
    w_fr = w_mr[SW-1:0];
    if (w_mr[SW+1]) begin
      w_ef = r_exp + XW'(1);
      w_fr = w_mr[SW:1];
    end
    w_res = {r_sx, w_ef[EW-1:0], w_fr};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_spec) begin
      w_res = r_spec_val;
    end else if (r_zero) begin
      w_res = {(r_rm == RM_NINF), {(W-1){1'b0}}};
    end else if (int'(w_ef) >= EMAX) begin
      w_res = {r_sx, {EW{1'b1}}, {SW{1'b0}}};
      w_ovf = 1'b1;
    end else if (int'(w_ef) <= 0) begin
      w_res = {r_sx, {(W-1){1'b0}}};
      w_unf = 1'b1;
    end
  end

  // operand capture, per-stage datapath, result write on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_op       <= 1'b0;
      r_rm       <= '0;
      r_sx       <= 1'b0;
      r_sy       <= 1'b0;
      r_ex       <= '0;
      r_ey       <= '0;
      r_mx       <= '0;
      r_my       <= '0;
      r_st       <= 1'b0;
      r_sum      <= '0;
      r_exp      <= '0;
      r_zero     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
      r_res      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (w_start) begin
        r_x  <= Data_X;
        r_y  <= Data_Y;
        r_op <= add_subt;
        r_rm <= r_mode;
      end
      case (r_state)
        S_LOAD: begin
          r_sx       <= w_swap ? w_ys : w_xs;
          r_sy       <= w_swap ? w_xs : w_ys;
          r_ex       <= w_swap ? w_ye : w_xe;
          r_ey       <= w_swap ? w_xe : w_ye;
          r_mx       <= w_swap ? w_ym : w_xm;
          r_my       <= w_swap ? w_xm : w_ym;
          r_spec     <= w_spec;
          r_spec_val <= w_spec_val;
        end
        S_ALIGN: begin
          r_my <= w_mys;
          r_st <= w_lost;
        end
        S_ADD: begin
          if (r_sx == r_sy) r_sum <= r_mx + r_my;
          else r_sum <= r_mx - r_my - {{(N-1){1'b0}}, r_st};
        end
        S_NORM: begin
          r_zero <= (r_sum == '0);
          if (r_sum[N-1]) begin
            r_sum <= {1'b0, r_sum[N-1:1]};
            r_st  <= r_st | r_sum[0];
            r_exp <= {2'b00, r_ex} + XW'(1);
          end else begin
            r_sum <= r_sum << w_lz;
            r_exp <= {2'b00, r_ex} - {{(XW-EWR){1'b0}}, w_lz};
          end
        end
        default: ;
      endcase
      if (w_fin) begin
        r_res <= w_res;
        r_ovf <= w_ovf;
        r_unf <= w_unf;
      end
    end
  end

  assign ready             = r_ready;
  assign final_result_ieee = r_res;
  assign overflow_flag     = r_ovf;
  assign underflow_flag    = r_unf;

endmodule

// File: tb/tb_fpu_add_subtract_function.sv
// Bench for fpu_add_subtract_function (default build).
// Directed cases plus random ops against an exact-arithmetic model.
module tb_fpu_add_subtract_function;

  logic        clk = 1'b0;
  logic        rst, rst_FSM, beg_FSM;
  logic [31:0] Data_X, Data_Y;
  logic        add_subt;
  logic [1:0]  r_mode;
  logic        overflow_flag, underflow_flag, ready;
  logic [31:0] final_result_ieee;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_add_subtract_function dut (
    .clk              (clk),
    .rst              (rst),
    .rst_FSM          (rst_FSM),
    .beg_FSM          (beg_FSM),
    .Data_X           (Data_X),
    .Data_Y           (Data_Y),
    .add_subt         (add_subt),
    .r_mode           (r_mode),
    .overflow_flag    (overflow_flag),
    .underflow_flag   (underflow_flag),
    .ready            (ready),
    .final_result_ieee(final_result_ieee)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // exact sum on a wide integer grid, then one rounding step
  function automatic logic [33:0] model(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic op,
                                        input logic [1:0] rm);
    logic [299:0] a, b, mag, rem, half, one;
    logic sx, sy, sg, inc;
    logic [24:0] m;
    int p, e;
    sx = x[31];
    sy = y[31] ^ op;
    a = '0;
    b = '0;
    one = 300'd1;
    if (x[30:23] != 8'd0)
      a = 300'({1'b1, x[22:0]}) << (int'(x[30:23]) - 1);
    if (y[30:23] != 8'd0)
      b = 300'({1'b1, y[22:0]}) << (int'(y[30:23]) - 1);
    if (sx == sy) begin
      mag = a + b;
      sg = sx;
    end else if (a >= b) begin
      mag = a - b;
      sg = sx;
    end else begin
      mag = b - a;
      sg = sy;
    end
    if (mag == '0) return {2'b00, (rm == 2'b10), 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (p >= 23) begin
      m = 25'(mag >> (p - 23));
      rem = mag & ((one << (p - 23)) - one);
      half = (p >= 24) ? (one << (p - 24)) : '0;
    end else begin
      m = 25'(mag << (23 - p));
      rem = '0;
      half = '0;
    end
    case (rm)
      2'b01: inc = !sg && (rem != '0);
      2'b10: inc = sg && (rem != '0);
      2'b11: inc = (rem > half) || (rem == half && rem != '0 && m[0]);
      default: inc = 1'b0;
    endcase
    m = m + 25'(inc);
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {2'b10, sg, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, sg, 31'd0};
    return {2'b00, sg, e[7:0], m[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic op, input logic [1:0] rm,
                        output int lat);
    @(negedge clk);
    Data_X = x;
    Data_Y = y;
    add_subt = op;
    r_mode = rm;
    beg_FSM = 1'b1;
    @(posedge clk);
    #1;
    beg_FSM = 1'b0;
    Data_X = $urandom;
    Data_Y = $urandom;
    add_subt = 1'($urandom);
    r_mode = 2'($urandom);
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic dir(input string tag, input logic [31:0] x,
                     input logic [31:0] y, input logic op,
                     input logic [1:0] rm, input logic [31:0] er,
                     input logic eo, input logic eu);
    int lat;
    run_op(x, y, op, rm, lat);
    check({tag, "_lat"}, 64'(lat), 64'd6);
    check({tag, "_res"}, 64'(final_result_ieee), 64'(er));
    check({tag, "_flags"}, 64'({overflow_flag, underflow_flag}),
          64'({eo, eu}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] x, y, prev;
    logic [33:0] exp_v;
    logic op;
    logic [1:0] rm;

    rst = 1'b1;
    rst_FSM = 1'b0;
    beg_FSM = 1'b0;
    Data_X = '0;
    Data_Y = '0;
    add_subt = 1'b0;
    r_mode = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_res", 64'(final_result_ieee), 64'd0);
    check("rst_rdy", 64'(ready), 64'd0);
    check("rst_flags", 64'({overflow_flag, underflow_flag}), 64'd0);

    @(negedge clk);
    rst_FSM = 1'b1;
    @(negedge clk);
    rst_FSM = 1'b0;

    dir("add21_31", 32'h40066666, 32'h40466666, 1'b0, 2'b01,
        32'h40A66666, 1'b0, 1'b0);
    dir("sub21_31", 32'h40066666, 32'h40466666, 1'b1, 2'b01,
        32'hBF800000, 1'b0, 1'b0);
    dir("zero_rm10", 32'h3F800000, 32'h3F800000, 1'b1, 2'b10,
        32'h80000000, 1'b0, 1'b0);
    dir("zero_rm11", 32'h3F800000, 32'h3F800000, 1'b1, 2'b11,
        32'h00000000, 1'b0, 1'b0);
    dir("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b11,
        32'h7F800000, 1'b1, 1'b0);
    dir("unf", 32'h00800001, 32'h00800000, 1'b1, 2'b11,
        32'h00000000, 1'b0, 1'b1);
    dir("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 2'b11,
        32'h3F800000, 1'b0, 1'b0);
    dir("tie_pinf", 32'h3F800000, 32'h33800000, 1'b0, 2'b01,
        32'h3F800001, 1'b0, 1'b0);
    dir("flush_y", 32'hC0400000, 32'h00012345, 1'b0, 2'b00,
        32'hC0400000, 1'b0, 1'b0);

    for (int k = 0; k < 80; k++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 4))
        0: y = {y[31], x[30:23], y[22:0]};
        1: y = {y[31], x[30:23] - 8'(k % 30), y[22:0]};
        2: y = {x[31], x[30:0] ^ {28'd0, y[3:0]}};
        3: y = {y[31], 8'd0, y[22:0]};
        default: ;
      endcase
      op = 1'($urandom);
      rm = 2'($urandom);
      exp_v = model(x, y, op, rm);
      run_op(x, y, op, rm, lat);
      check($sformatf("rnd%0d_lat", k), 64'(lat), 64'd6);
      check($sformatf("rnd%0d %h %s %h rm%0d", k, x, op ? "-" : "+",
                      y, rm),
            64'({overflow_flag, underflow_flag, final_result_ieee}),
            64'(exp_v));
    end

    prev = final_result_ieee;
    @(negedge clk);
    Data_X = 32'h41200000;
    Data_Y = 32'h40000000;
    add_subt = 1'b0;
    r_mode = 2'b11;
    beg_FSM = 1'b1;
    @(negedge clk);
    beg_FSM = 1'b0;
    @(negedge clk);
    rst_FSM = 1'b1;
    @(negedge clk);
    rst_FSM = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_rdy", 64'(ready), 64'd0);
    check("abort_hold", 64'(final_result_ieee), 64'(prev));

    dir("after_abort", 32'h41200000, 32'h40000000, 1'b0, 2'b11,
        32'h41400000, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_res", 64'(final_result_ieee), 64'd0);
    check("rst2_rdy", 64'(ready), 64'd0);
    check("rst2_flags", 64'({overflow_flag, underflow_flag}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
